// File: rtl/jstk_spi_slave.sv
// jstk_spi_slave: SPI mode-0 responder emulating the PmodJSTK end of the 5-byte joystick frame.
// SPI pins are oversampled on CLK; MISO is shifted on SCLK falls, MOSI captured on SCLK rises.
module jstk_spi_slave #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [1:0]  LED_INIT    = 2'b00
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SS,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [9:0]  X_POS,
   input  logic [9:0]  Y_POS,
   input  logic [2:0]  BTN,
   output logic [1:0]  LED,
   output logic [39:0] RXDATA,
   output logic        FRAME_DONE,
   output logic        FRAME_ERR
);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic [1:0]  ss_pipe, sclk_pipe;
   logic        mosi_d;
   logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic        load, end_frame, do_rx, do_tx;
   logic [39:0] tx, rx;
   logic [5:0]  cnt;
   logic        cmd_chk;

   // Synchronizers reset low so a frame already in progress at reset never looks like a fresh SS fall
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ss_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_pipe   <= '0;
         sclk_pipe <= '0;
         mosi_d    <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_pipe   <= {ss_pipe[0], ss_sync[SYNC_STAGES-1]};
         sclk_pipe <= {sclk_pipe[0], sclk_sync[SYNC_STAGES-1]};
         mosi_d    <= mosi_sync[SYNC_STAGES-1];
      end
   end

   assign ss_fall   = ss_pipe[1] & ~ss_pipe[0];
   assign ss_rise   = ~ss_pipe[1] & ss_pipe[0];
   assign sclk_rise = ~sclk_pipe[1] & sclk_pipe[0];
   assign sclk_fall = sclk_pipe[1] & ~sclk_pipe[0];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= WAIT_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      load      = (state == IDLE) && ss_fall;
      end_frame = (state == ACTIVE) && ss_rise;
      do_rx     = (state == ACTIVE) && sclk_rise && !ss_rise;
      do_tx     = (state == ACTIVE) && sclk_fall && !ss_rise;
      state_nxt = (state == WAIT_IDLE && ss_pipe[0]) ? IDLE :
                  load      ? ACTIVE :
                  end_frame ? IDLE : state;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx         <= '0;
         rx         <= '0;
         cnt        <= '0;
         cmd_chk    <= 1'b0;
         MISO       <= 1'b0;
         LED        <= LED_INIT;
         RXDATA     <= '0;
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
         cmd_chk    <= 1'b0;
         // rx holds byte0 in its low byte the cycle after the 8th rise
         if (cmd_chk && rx[7]) LED <= rx[1:0];
         if (load) begin
            tx   <= {X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTN};
            cnt  <= '0;
            MISO <= X_POS[7];
         end else if (end_frame) begin
            MISO <= 1'b0;
            if (cnt == 6'd40) begin
               RXDATA     <= rx;
               FRAME_DONE <= 1'b1;
            end else FRAME_ERR <= 1'b1;
         end else if (do_rx) begin
            rx      <= {rx[38:0], mosi_d};
            cnt     <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
            cmd_chk <= (cnt == 6'd7);
         end else if (do_tx) begin
            tx   <= {tx[38:0], 1'b0};
            MISO <= (cnt >= 6'd40) ? 1'b0 : tx[38];
         end
      end
   end
endmodule

// File: tb/tb_jstk_spi_slave.sv
// tb_jstk_spi_slave: table-driven frames plus hand sequences for mid-frame input change and reset.
// Expected MISO bits are queued as each bit is driven and popped when the master samples.
module tb_jstk_spi_slave;
   localparam logic [1:0] LED_INIT = 2'b00;
   logic        CLK = 0, RST = 0, SS = 1, SCLK = 0, MOSI = 0;
   logic        MISO, FRAME_DONE, FRAME_ERR;
   logic [9:0]  X_POS = 0, Y_POS = 0;
   logic [2:0]  BTN = 0;
   logic [1:0]  LED;
   logic [39:0] RXDATA;
   int          checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
   bit          q[$];
   logic [39:0] rx_exp = 0;

   typedef struct {
      logic [9:0]  x, y;
      logic [2:0]  btn;
      logic [39:0] d;
      int          nbits;
      logic [1:0]  led;
      int          done, err;
   } vec_t;
   vec_t tab[5];

   jstk_spi_slave #(.SYNC_STAGES(2), .LED_INIT(LED_INIT)) dut (
      .CLK(CLK), .RST(RST), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .X_POS(X_POS), .Y_POS(Y_POS), .BTN(BTN), .LED(LED), .RXDATA(RXDATA),
      .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR));

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (FRAME_DONE) done_cnt++;
      if (FRAME_ERR) err_cnt++;
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [39:0] d, input int nbits, input int chg_at, input int rst_at);
      logic [39:0] tx;
      bit dead;
      dead = 0;
      tx = {X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTN};
      done_cnt = 0;
      err_cnt = 0;
      SS = 0;
      wclk(8);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) begin
            X_POS = 10'h000;
            Y_POS = 10'h3FF;
            BTN = 3'b010;
         end
         if (i == rst_at) begin
            RST = 0;
            wclk(3);
            chk("rst_miso", {39'b0, MISO}, 40'd0);
            chk("rst_led", {38'b0, LED}, {38'b0, LED_INIT});
            chk("rst_rxdata", RXDATA, 40'd0);
            RST = 1;
            dead = 1;
            wclk(2);
         end
         MOSI = (i < 40) ? d[39-i] : 1'b1;
         q.push_back((dead || i >= 40) ? 1'b0 : tx[39-i]);
         wclk(8);
         chk($sformatf("miso_bit%0d", i), {39'b0, MISO}, {39'b0, q.pop_front()});
         SCLK = 1;
         wclk(8);
         SCLK = 0;
      end
      wclk(8);
      SS = 1;
      wclk(10);
      chk("miso_after_ss", {39'b0, MISO}, 40'd0);
   endtask

   task automatic end_checks(input string tag, input logic [1:0] led, input int done, input int err);
      chk({tag, "_led"}, {38'b0, LED}, {38'b0, led});
      chk({tag, "_rxdata"}, RXDATA, rx_exp);
      chk({tag, "_done"}, done_cnt, done);
      chk({tag, "_err"}, err_cnt, err);
   endtask

   initial begin
      tab[0] = '{10'h2A5, 10'h13C, 3'b101, 40'h8300000000, 40, 2'b11, 1, 0};
      tab[1] = '{10'h2A5, 10'h13C, 3'b101, 40'h0200000000, 40, 2'b11, 1, 0};
      tab[2] = '{10'h155, 10'h2AA, 3'b011, 40'h8100000000, 12, 2'b01, 0, 1};
      tab[3] = '{10'h3FF, 10'h001, 3'b111, 40'h4000000000, 48, 2'b01, 0, 1};
      tab[4] = '{10'h0F0, 10'h30F, 3'b100, 40'h82DEADBEEF, 40, 2'b10, 1, 0};
      wclk(5);
      chk("reset_miso", {39'b0, MISO}, 40'd0);
      chk("reset_led", {38'b0, LED}, {38'b0, LED_INIT});
      chk("reset_rxdata", RXDATA, 40'd0);
      chk("reset_done", {39'b0, FRAME_DONE}, 40'd0);
      chk("reset_err", {39'b0, FRAME_ERR}, 40'd0);
      RST = 1;
      wclk(10);
      for (int i = 0; i < 5; i++) begin
         X_POS = tab[i].x;
         Y_POS = tab[i].y;
         BTN = tab[i].btn;
         run_frame(tab[i].d, tab[i].nbits, -1, -1);
         if (tab[i].done != 0) rx_exp = tab[i].d;
         end_checks($sformatf("vec%0d", i), tab[i].led, tab[i].done, tab[i].err);
      end
      X_POS = 10'h2A5;
      Y_POS = 10'h13C;
      BTN = 3'b101;
      run_frame(40'h01A5A5A5A5, 40, 16, -1);
      rx_exp = 40'h01A5A5A5A5;
      end_checks("snapshot", 2'b10, 1, 0);
      X_POS = 10'h2A5;
      Y_POS = 10'h13C;
      BTN = 3'b101;
      run_frame(40'h8300000000, 40, -1, 20);
      rx_exp = 40'd0;
      end_checks("midreset", LED_INIT, 0, 0);
      run_frame(40'h8112345678, 40, -1, -1);
      rx_exp = 40'h8112345678;
      end_checks("after_reset", 2'b01, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jstk_spi_slave.md
Name: jstk_spi_slave

Overview:
- SPI mode-0 responder that emulates the PmodJSTK device end of the 5-byte joystick transaction.
- Returns X/Y position and button state to an SPI master, and decodes the master's LED command byte.
- Sits on the bench and in loopback builds opposite the existing master-side SPI controller/interface pair.
- All SPI pins are asynchronous inputs; the block oversamples them on the system clock.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SS/SCLK/MOSI synchronizers (minimum 2).
- LED_INIT, 2'b00, LED output value after reset.

Ports:
- CLK  input  1  system clock; must be at least 8x the SCLK frequency.
- RST  input  1  asynchronous, active-low reset.
- SS  input  1  slave select from master, active low, asynchronous.
- SCLK  input  1  serial clock from master, idle low, asynchronous.
- MOSI  input  1  master-out data, asynchronous.
- MISO  output  1  slave-out data.
- X_POS  input  10  joystick X value to report.
- Y_POS  input  10  joystick Y value to report.
- BTN  input  3  {btn2, btn1, stick button}.
- LED  output  2  LED state last commanded by the master.
- RXDATA  output  40  all bytes received in the last good frame; byte0 is in [39:32].
- FRAME_DONE  output  1  one-cycle pulse when a good 40-bit frame ends.
- FRAME_ERR  output  1  one-cycle pulse when a frame ends with a bit count other than 40.

Behaviour:
- Reset values: MISO=0, LED=LED_INIT, RXDATA=0, FRAME_DONE=0, FRAME_ERR=0, state=WAIT_IDLE, bit count=0, shift registers=0.
- Input conditioning: SS, SCLK and MOSI each pass through a SYNC_STAGES synchronizer, followed by one edge-detect register. Detected events are ss_fall, ss_rise, sclk_rise and sclk_fall; each is a single-cycle pulse.
- Event latency: any pin edge produces its internal event SYNC_STAGES+1 CLK cycles later.
- State WAIT_IDLE: entered from reset. Ignores all traffic until synchronized SS is high, then moves to IDLE. This prevents joining a frame that is already in progress.
- State IDLE: MISO=0. On ss_fall:
  - load the tx shift register with {X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTN};
  - set bit count to 0;
  - drive MISO = tx[39] on the next cycle;
  - move to ACTIVE.
- State ACTIVE:
  - On sclk_rise: shift the synchronized MOSI into the rx shift register (LSB in, MSB first). Increment the bit count, saturating at 63.
  - On sclk_fall: shift tx left by one and drive MISO = new tx[39]. When bit count is 40 or more, MISO=0.
  - The MISO update on sclk_fall lands within SYNC_STAGES+2 CLK cycles of the physical SCLK fall.
  - Command decode: on the sclk_rise that makes bit count 8, inspect the received byte0. If byte0[7]=1, LED <= byte0[1:0] on the following cycle. Otherwise LED is unchanged.
- Frame end: on ss_rise, return to IDLE.
  - If bit count = 40: RXDATA <= rx register and FRAME_DONE pulses.
  - Otherwise: RXDATA is held and FRAME_ERR pulses.
  - Pulses assert exactly one cycle after ss_rise is detected. MISO returns to 0.
- Simultaneous events: ss_rise has priority over sclk_rise and sclk_fall in the same cycle; the SCLK event is discarded. If ss_fall and an SCLK edge coincide, the SCLK edge is ignored.
- Input snapshot: X_POS, Y_POS and BTN are sampled only at ss_fall. Changes during a frame do not alter the bytes being sent.
- Short frames:
  - An aborted frame (SS high before 8 bits) never updates LED.
  - A frame aborted after 8 bits keeps the LED update and raises FRAME_ERR.
- Over-length frames: more than 40 clocks gives MISO=0 for the extra bits and FRAME_ERR at the end.
- Reset mid-frame: all outputs return to reset values immediately; the block re-enters WAIT_IDLE.

Test Plan:
- Nominal frame: X_POS=10'h2A5, Y_POS=10'h13C, BTN=3'b101; master sends 0x83,0,0,0,0 at 66.67 kHz -> MISO bytes A5,02,3C,01,05; LED=2'b11; RXDATA=40'h8300000000; one FRAME_DONE pulse, no FRAME_ERR.
- Command without the flag bit: master sends byte0=0x02 -> LED unchanged from its previous value 2'b11; FRAME_DONE pulses.
- Input change mid-frame: X_POS changes to 10'h000 after byte1 -> the remaining bytes still carry the snapshot values 3C,01,05.
- Aborted frame: SS rises after 12 SCLK cycles with byte0=0x81 -> LED=2'b01, FRAME_ERR pulses once, RXDATA holds its previous value, MISO=0 after SS rises.
- Over-length frame: 48 SCLK cycles -> bits 41..48 on MISO are 0; FRAME_ERR pulses and FRAME_DONE does not.
- Reset during frame: RST low at bit 20 with SS held low -> MISO=0 and LED=LED_INIT. The rest of the frame is ignored with no pulses. The next full frame after SS goes high is serviced normally.
